// File: rtl/mux_pkg.sv
// Shared sizing helpers and the sideband record that rides alongside data
// through every level of the pipelined selector tree.
package mux_pkg;

    localparam int SB_SEL_W = 32;

    typedef struct packed {
        logic                err;
        logic [SB_SEL_W-1:0] sel_rem;
    } sideband_t;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lvl_bits(input int radix);
        return $clog2(radix);
    endfunction

    function automatic int num_stages(input int n, input int radix);
        int lb;
        lb = lvl_bits(radix);
        return (sel_width(n) + lb - 1) / lb;
    endfunction

    // Number of lanes entering stage k; each stage divides by RADIX, rounding up.
    function automatic int stage_fanin(input int n, input int radix, input int k);
        int lanes;
        lanes = n;
        for (int i = 0; i < k; i++) begin
            lanes = (lanes + radix - 1) / radix;
        end
        return lanes;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered RADIX:1 level of the selector tree. Every group of RADIX
// input lanes collapses to one output lane using the low sel bits of the sideband.
module mux_tree_stage
    import mux_pkg::*;
#(
    parameter  int LANES_IN   = 8,
    parameter  int RADIX      = 8,
    parameter  int DATA_WIDTH = 1,
    localparam int LANES_OUT  = (LANES_IN + RADIX - 1) / RADIX
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            up_valid_i,
    input  logic [LANES_IN*DATA_WIDTH-1:0]  up_data_i,
    input  sideband_t                       up_sb_i,
    output logic                            up_ready_o,
    output logic                            dn_valid_o,
    output logic [LANES_OUT*DATA_WIDTH-1:0] dn_data_o,
    output sideband_t                       dn_sb_o,
    input  logic                            dn_ready_i
);

    localparam int LVL_BITS = lvl_bits(RADIX);
    localparam int PAD_W    = LANES_OUT * RADIX * DATA_WIDTH;

    logic                            valid_q;
    logic [LANES_OUT*DATA_WIDTH-1:0] data_q;
    logic [LANES_OUT*DATA_WIDTH-1:0] data_d;
    sideband_t                       sb_q;
    sideband_t                       sb_d;
    logic [PAD_W-1:0]                padded;
    logic [LVL_BITS-1:0]             idx;

    // A stage may accept whenever it is empty or its content leaves this cycle.
    assign up_ready_o = !valid_q || dn_ready_i;

    always_comb begin
        padded = '0;
        padded[LANES_IN*DATA_WIDTH-1:0] = up_data_i;
        idx    = up_sb_i.sel_rem[LVL_BITS-1:0];
        data_d = '0;
        for (int g = 0; g < LANES_OUT; g++) begin
            data_d[g*DATA_WIDTH +: DATA_WIDTH] =
                padded[(g*RADIX + int'(idx))*DATA_WIDTH +: DATA_WIDTH];
        end
        sb_d         = up_sb_i;
        sb_d.sel_rem = up_sb_i.sel_rem >> LVL_BITS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sb_q    <= '0;
        end else if (up_ready_o) begin
            valid_q <= up_valid_i;
            data_q  <= data_d;
            sb_q    <= sb_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;
    assign dn_sb_o    = sb_q;

endmodule

// File: rtl/pipelined_mux_tree.sv
// Pipelined NUM_INPUTS:1 lane selector built from registered RADIX:1 levels,
// with a valid/ready chain that lets bubbles collapse into empty levels.
module pipelined_mux_tree
    import mux_pkg::*;
#(
    parameter  int NUM_INPUTS = 32,
    parameter  int DATA_WIDTH = 1,
    parameter  int RADIX      = 8,
    localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]                 in_sel,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_sel_err,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int NUM_STAGES = num_stages(NUM_INPUTS, RADIX);
    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_INPUTS);

    if (RADIX < 2 || !is_pow2(RADIX)) begin : g_bad_radix
        $error("pipelined_mux_tree: RADIX must be a power of 2 and >= 2");
    end
    if (NUM_INPUTS < 2) begin : g_bad_inputs
        $error("pipelined_mux_tree: NUM_INPUTS must be >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("pipelined_mux_tree: DATA_WIDTH must be >= 1");
    end
    if (SEL_W > SB_SEL_W) begin : g_bad_sel
        $error("pipelined_mux_tree: select too wide for sideband");
    end

    sideband_t                        sb0;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] data0;
    logic                             unused_sel_rem;

    // Out-of-range selects are zeroed here so every later level just forwards zeros.
    always_comb begin
        sb0         = '0;
        sb0.err     = {1'b0, in_sel} >= NUM_IN_L;
        sb0.sel_rem = SB_SEL_W'(in_sel);
        data0       = sb0.err ? '0 : in_data;
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int LIN  = stage_fanin(NUM_INPUTS, RADIX, k);
        localparam int LOUT = stage_fanin(NUM_INPUTS, RADIX, k + 1);

        logic                       up_valid;
        logic                       up_ready;
        logic [LIN*DATA_WIDTH-1:0]  up_data;
        sideband_t                  up_sb;
        logic                       dn_valid;
        logic                       dn_ready;
        logic [LOUT*DATA_WIDTH-1:0] dn_data;
        sideband_t                  dn_sb;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = data0;
            assign up_sb    = sb0;
        end else begin : g_link
            assign up_valid = g_stage[k-1].dn_valid;
            assign up_data  = g_stage[k-1].dn_data;
            assign up_sb    = g_stage[k-1].dn_sb;
        end

        if (k == NUM_STAGES - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_next
            assign dn_ready = g_stage[k+1].up_ready;
        end

        mux_tree_stage #(
            .LANES_IN   (LIN),
            .RADIX      (RADIX),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid_i (up_valid),
            .up_data_i  (up_data),
            .up_sb_i    (up_sb),
            .up_ready_o (up_ready),
            .dn_valid_o (dn_valid),
            .dn_data_o  (dn_data),
            .dn_sb_o    (dn_sb),
            .dn_ready_i (dn_ready)
        );
    end

    assign in_ready       = g_stage[0].up_ready;
    assign out_valid      = g_stage[NUM_STAGES-1].dn_valid;
    assign out_data       = g_stage[NUM_STAGES-1].dn_data;
    assign out_sel_err    = g_stage[NUM_STAGES-1].dn_sb.err;
    assign unused_sel_rem = ^g_stage[NUM_STAGES-1].dn_sb.sel_rem;

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Bench for pipelined_mux_tree: default 32x1/radix-8 instance and a 5x8/radix-2
// instance, each with a queue-based reference scoreboard.
module tb_pipelined_mux_tree;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] in_data_a;
    logic [4:0]  in_sel_a;
    logic        in_valid_a, in_ready_a;
    logic [0:0]  out_data_a;
    logic        out_sel_err_a, out_valid_a, out_ready_a;

    logic [39:0] in_data_b;
    logic [2:0]  in_sel_b;
    logic        in_valid_b, in_ready_b;
    logic [7:0]  out_data_b;
    logic        out_sel_err_b, out_valid_b, out_ready_b;

    pipelined_mux_tree u_dut_a (
        .clk(clk), .rst(rst),
        .in_data(in_data_a), .in_sel(in_sel_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_sel_err(out_sel_err_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a)
    );

    pipelined_mux_tree #(.NUM_INPUTS(5), .DATA_WIDTH(8), .RADIX(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_data(in_data_b), .in_sel(in_sel_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_sel_err(out_sel_err_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        logic [4:0] sel;
        logic       exp_data;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];

    function automatic exp_t ref_a(input logic [31:0] d, input int sel);
        exp_t r;
        r.err  = (sel >= 32);
        r.data = r.err ? 8'h00 : {7'b0, d[sel]};
        return r;
    endfunction

    function automatic exp_t ref_b(input logic [39:0] d, input int sel);
        exp_t r;
        r.err  = (sel >= 5);
        r.data = r.err ? 8'h00 : d[sel*8 +: 8];
        return r;
    endfunction

    // Scoreboards: accepted inputs are queued, consumed outputs are popped in order.
    logic       stall_a = 1'b0, stall_b = 1'b0;
    logic [8:0] hold_a, hold_b;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qa.delete();
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                check("a_stall_valid", out_valid_a, 1'b1);
                check("a_stall_hold", {out_sel_err_a, 7'b0, out_data_a}, hold_a);
            end
            if (out_valid_a && out_ready_a) begin
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_output actual=%0h required=none", out_data_a);
                end else begin
                    e = qa.pop_front();
                    check("a_out_data", out_data_a, e.data);
                    check("a_out_err", out_sel_err_a, e.err);
                end
            end
            if (in_valid_a && in_ready_a) qa.push_back(ref_a(in_data_a, int'(in_sel_a)));
            stall_a = out_valid_a && !out_ready_a;
            hold_a  = {out_sel_err_a, 7'b0, out_data_a};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            qb.delete();
            stall_b = 1'b0;
        end else begin
            if (stall_b) begin
                check("b_stall_valid", out_valid_b, 1'b1);
                check("b_stall_hold", {out_sel_err_b, out_data_b}, hold_b);
            end
            if (out_valid_b && out_ready_b) begin
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_output actual=%0h required=none", out_data_b);
                end else begin
                    e = qb.pop_front();
                    check("b_out_data", out_data_b, e.data);
                    check("b_out_err", out_sel_err_b, e.err);
                end
            end
            if (in_valid_b && in_ready_b) qb.push_back(ref_b(in_data_b, int'(in_sel_b)));
            stall_b = out_valid_b && !out_ready_b;
            hold_b  = {out_sel_err_b, out_data_b};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    logic [31:0] pattern;
    vec_t        vecs[32];
    logic [7:0]  b_exp_data[2];
    logic        b_exp_err[2];

    initial begin
        in_data_a = '0; in_sel_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        in_data_b = '0; in_sel_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        pattern = 32'hA5C3_0F96;
        for (int i = 0; i < 32; i++) begin
            vecs[i].sel      = 5'(i);
            vecs[i].exp_data = pattern[i];
        end
        b_exp_data[0] = 8'h14; b_exp_err[0] = 1'b0;
        b_exp_data[1] = 8'h00; b_exp_err[1] = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", out_valid_a, 1'b0);
        check("rst_out_data", out_data_a, 1'b0);
        check("rst_out_err", out_sel_err_a, 1'b0);
        check("rst_in_ready", in_ready_a, 1'b1);
        check("rst_b_out_valid", out_valid_b, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back sweep at defaults, latency 2
        in_data_a = pattern;
        for (int c = 0; c < 34; c++) begin
            if (c < 32) begin
                in_valid_a = 1'b1;
                in_sel_a   = vecs[c].sel;
            end else begin
                in_valid_a = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) begin
                check("sweep_valid", out_valid_a, 1'b1);
                check("sweep_data", out_data_a, vecs[c-2].exp_data);
            end else begin
                check("sweep_latency", out_valid_a, 1'b0);
            end
            tick();
        end
        in_valid_a = 1'b0;
        repeat (2) tick();

        // Wide/odd instance: sel=4 then sel=5, latency 3
        in_data_b = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        for (int t = 0; t < 2; t++) begin
            in_sel_b   = (t == 0) ? 3'd4 : 3'd5;
            in_valid_b = 1'b1;
            for (int c = 0; c <= 3; c++) begin
                @(negedge clk);
                if (c == 3) begin
                    check("odd_valid", out_valid_b, 1'b1);
                    check("odd_data", out_data_b, b_exp_data[t]);
                    check("odd_err", out_sel_err_b, b_exp_err[t]);
                end else begin
                    check("odd_latency", out_valid_b, 1'b0);
                end
                tick();
                in_valid_b = 1'b0;
            end
        end

        // Reset mid-stream with two items in flight
        out_ready_a = 1'b1;
        in_valid_a = 1'b1; in_sel_a = 5'd1;
        tick();
        in_sel_a = 5'd2;
        tick();
        in_valid_a = 1'b0;
        check("midrst_pre_valid", out_valid_a, 1'b1);
        check("midrst_pre_data", out_data_a, pattern[1]);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid_a, 1'b0);
        check("midrst_out_data", out_data_a, 1'b0);
        check("midrst_in_ready", in_ready_a, 1'b1);
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", in_ready_a, 1'b1);
        check("postrst_out_valid", out_valid_a, 1'b0);
        tick();

        // Backpressure: 4 stalled cycles, 3 items offered
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; in_sel_a = 5'd4;
        @(negedge clk); check("bp_ready_c0", in_ready_a, 1'b1); tick();
        in_sel_a = 5'd3;
        @(negedge clk); check("bp_ready_c1", in_ready_a, 1'b1); tick();
        in_sel_a = 5'd2;
        @(negedge clk);
        check("bp_full_ready", in_ready_a, 1'b0);
        check("bp_out_valid", out_valid_a, 1'b1);
        tick();
        @(negedge clk);
        check("bp_full_ready2", in_ready_a, 1'b0);
        check("bp_out_data", out_data_a, pattern[4]);
        tick();
        out_ready_a = 1'b1;
        @(negedge clk); check("bp_release_ready", in_ready_a, 1'b1); tick();
        in_valid_a = 1'b0;
        repeat (4) begin @(negedge clk); tick(); end
        check("bp_drained", qa.size(), 0);

        // Bubble collapse: A, idle, B with A stalled one cycle
        in_valid_a = 1'b1; in_sel_a = 5'd1;
        @(negedge clk); tick();
        in_valid_a = 1'b0;
        @(negedge clk); tick();
        in_valid_a = 1'b1; in_sel_a = 5'd3; out_ready_a = 1'b0;
        @(negedge clk);
        check("bub_a_valid", out_valid_a, 1'b1);
        check("bub_a_data", out_data_a, pattern[1]);
        check("bub_in_ready", in_ready_a, 1'b1);
        tick();
        in_valid_a = 1'b0; out_ready_a = 1'b1;
        @(negedge clk);
        check("bub_a_hold", out_data_a, pattern[1]);
        tick();
        @(negedge clk);
        check("bub_b_valid", out_valid_a, 1'b1);
        check("bub_b_data", out_data_a, pattern[3]);
        tick();
        @(negedge clk);
        check("bub_empty", out_valid_a, 1'b0);
        tick();

        // Random traffic on both instances against the scoreboards
        for (int c = 0; c < 10000; c++) begin
            in_valid_a  = ($urandom_range(0, 3) != 0);
            in_data_a   = $urandom;
            in_sel_a    = 5'($urandom);
            out_ready_a = ($urandom_range(0, 2) != 0);
            in_valid_b  = ($urandom_range(0, 3) != 0);
            in_data_b   = {8'($urandom), 32'($urandom)};
            in_sel_b    = 3'($urandom);
            out_ready_b = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            tick();
        end
        in_valid_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; out_ready_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tick();
        end
        check("rand_a_left", qa.size(), 0);
        check("rand_b_left", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
